// File: rtl/fma_bypass_ctrl_pkg.sv
// rtl/fma_bypass_ctrl_pkg.sv - shared FMA bypass constants and scoreboard entry type
package fma_bypass_ctrl_pkg;

  localparam int DEF_LAT = 4;
  localparam int DEF_AW  = 5;
  // Entries carry the widest supported address; narrower AW is zero-extended.
  localparam int MAX_AW  = 8;

  typedef struct packed {
    logic              v;
    logic [MAX_AW-1:0] rd;
  } sb_entry_t;

  function automatic logic src_match(input sb_entry_t e, input logic [MAX_AW-1:0] src);
    return e.v && (e.rd == src);
  endfunction

endpackage

// File: rtl/fma_bypass_ctrl_if.sv
// rtl/fma_bypass_ctrl_if.sv - FMA issue handshake with operand bypass selects
interface fma_bypass_ctrl_if
  import fma_bypass_ctrl_pkg::*;
#(
  parameter int AW = DEF_AW
);
  logic          iss_valid;
  logic          iss_ready;
  logic [AW-1:0] iss_xa;
  logic [AW-1:0] iss_za;
  logic [AW-1:0] iss_rd;
  logic [1:0]    bypsel;

  modport master (
    output iss_valid, iss_xa, iss_za, iss_rd,
    input  iss_ready, bypsel
  );

  modport slave (
    input  iss_valid, iss_xa, iss_za, iss_rd,
    output iss_ready, bypsel
  );
endinterface

// File: rtl/fma_src_match.sv
// rtl/fma_src_match.sv - resolves one source operand against the in-flight scoreboard
module fma_src_match
  import fma_bypass_ctrl_pkg::*;
#(
  parameter int LAT = DEF_LAT
) (
  input  sb_entry_t [LAT-1:0] sb,
  input  logic [MAX_AW-1:0]   src,
  output logic                hazard,
  output logic                bypass
);

  // Any younger match hides a stage-LAT match, so the youngest producer wins.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < LAT - 1; k++) begin
      hazard = hazard | src_match(sb[k], src);
    end
    bypass = ~hazard & src_match(sb[LAT-1], src);
  end

endmodule

// File: rtl/fma_bypass_ctrl.sv
// rtl/fma_bypass_ctrl.sv - FMAC issue scoreboard: hazard stall, stage-LAT bypass, writeback tracking
module fma_bypass_ctrl
  import fma_bypass_ctrl_pkg::*;
#(
  parameter int LAT = DEF_LAT,
  parameter int AW  = DEF_AW
) (
  input  logic                  clk,
  input  logic                  reset_n,
  fma_bypass_ctrl_if.slave      iss,
  input  logic                  flush,
  input  logic [63:0]           pre_result,
  output logic [63:0]           wbypass,
  output logic                  wb_valid,
  output logic [AW-1:0]         wb_rd,
  output logic [15:0]           stall_cnt
);

  sb_entry_t [LAT-1:0] sb;
  logic                hz_x, hz_z, by_x, by_z;
  logic                ready, accept, stall_inc;
  logic [MAX_AW-1:0]   xa_ext, za_ext, rd_ext;

  assign xa_ext = MAX_AW'(iss.iss_xa);
  assign za_ext = MAX_AW'(iss.iss_za);
  assign rd_ext = MAX_AW'(iss.iss_rd);

  fma_src_match #(.LAT(LAT)) u_match_x (
    .sb     (sb),
    .src    (xa_ext),
    .hazard (hz_x),
    .bypass (by_x)
  );

  fma_src_match #(.LAT(LAT)) u_match_z (
    .sb     (sb),
    .src    (za_ext),
    .hazard (hz_z),
    .bypass (by_z)
  );

  // Outputs are forced to their idle values while reset is held, before the first edge.
  assign ready         = ~reset_n | (~flush & ~hz_x & ~hz_z);
  assign accept        = reset_n & iss.iss_valid & ready;
  assign stall_inc     = iss.iss_valid & ~ready & ~flush;
  assign iss.iss_ready = ready;
  assign iss.bypsel    = accept ? {by_z, by_x} : 2'b00;

  assign wbypass  = pre_result;
  assign wb_valid = reset_n & sb[LAT-1].v;
  assign wb_rd    = sb[LAT-1].rd[AW-1:0];

  always_ff @(posedge clk) begin
    sb[0].rd <= rd_ext;
    for (int k = 1; k < LAT; k++) begin
      sb[k].rd <= sb[k-1].rd;
    end
    if (!reset_n) begin
      for (int k = 0; k < LAT; k++) begin
        sb[k].v <= 1'b0;
      end
      stall_cnt <= '0;
    end else begin
      sb[0].v <= accept;
      for (int k = 1; k < LAT; k++) begin
        sb[k].v <= sb[k-1].v & ~flush;
      end
      if (stall_inc && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

endmodule
